pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
Instruction-fetch front end of the 5-stage pipeline, directly upstream of the instruction memory. It owns the program counter and drives insEn/insAddr to the combinational instruction memory. It latches the returned instruction into the IF/ID pipeline register. It applies stall, flush/exception redirect and ID-resolved branch redirects with fixed priority, and it keeps a retired-fetch counter.

Parameters:
ADDR_W, 32, PC / instruction address width
INS_W, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
stallIf  in  1  hold PC (from stall controller)
stallId  in  1  hold IF/ID register (from stall controller)
flush  in  1  exception/eret redirect, highest priority
newPc  in  ADDR_W  redirect target when flush=1
branchFlag  in  1  taken branch/jump resolved in ID
branchTarget  in  ADDR_W  target when branchFlag=1
inst  in  INS_W  instruction word from instruction memory (same cycle as insAddr)
insEn  out  1  instruction memory enable
insAddr  out  ADDR_W  current PC to instruction memory
idPc  out  ADDR_W  PC of instruction held in IF/ID
idInst  out  INS_W  instruction held in IF/ID
idValid  out  1  IF/ID holds a real instruction (0 = bubble)
idMisalign  out  1  fetch address of held instruction had [1:0]!=0
fetchCount  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (async, rst=1): insEn=0, insAddr=RESET_PC, idPc=0, idInst=0, idValid=0, idMisalign=0, fetchCount=0.
- First rising edge after rst deasserts: insEn<=1, PC stays RESET_PC, IF/ID stays bubble. The first instruction is captured on the second edge. PC and IF/ID update only on edges where insEn is already 1.
- insAddr equals the PC register; combinational read, so inst is valid in the same cycle.
- Per-edge priority (insEn=1):
  1. flush=1: PC<=newPc; IF/ID<=bubble (idInst=0, idValid=0, idPc=0, idMisalign=0). Stall inputs are ignored.
  2. stallId=1: PC and IF/ID both hold. stallId=1 with stallIf=0 is treated as both stalled.
  3. stallIf=1, stallId=0: PC holds; IF/ID<=bubble.
  4. Otherwise: IF/ID<={PC, inst, valid=1, misalign=PC[1:0]!=0}, and PC<=branchFlag ? branchTarget : PC+4.
- branchFlag is honoured only in case 4. Under stall, ID holds the branch and reasserts it. The instruction fetched in the branch cycle (delay slot) is still captured.
- PC+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- A misaligned target (newPc or branchTarget [1:0]!=0) is loaded unmodified and driven on insAddr. The memory ignores bits [1:0]. idMisalign flags the word for the ID-stage exception logic.
- fetchCount increments by 1 exactly on case-4 edges and wraps at 2^32.
- rst asserted mid-operation: all state returns to reset values immediately, independent of clk. The insEn restart sequence repeats.
- No combinational path from any input to any output except through registers.

Decomposition:
- Shared defines header: RESET_PC value, ZeroWord, InsEnable/InsDisable, address/instruction width macros, PC increment constant (4). These already belong alongside the existing global defines.
- One natural sub-module: if_id_reg (IF/ID register with bubble/hold control).
- pc_fetch contains the PC state, priority logic and counter, and instantiates if_id_reg.

Test Plan:
- Reset release: rst 1->0, no stalls, memory returns word = address -> insEn=1 after edge 1. idPc/idInst = 0x0/0x0, 0x4/0x4, 0x8/0x8 on edges 2, 3, 4. fetchCount=3.
- Branch: at PC=0x10, branchFlag=1, branchTarget=0x40 for one cycle -> IF/ID gets 0x10. Next insAddr=0x40, next IF/ID idPc=0x40.
- Stall: stallIf=1, stallId=0 for 2 cycles at PC=0x20 -> insAddr holds 0x20, idValid=0 for 2 cycles, fetchCount frozen. stallIf=stallId=1 -> IF/ID content and PC unchanged.
- Flush vs stall/branch: flush=1, newPc=0x180, stallIf=stallId=1, branchFlag=1 -> insAddr=0x180, idValid=0. Next normal edge captures idPc=0x180.
- Wrap and misalign: PC=0xFFFF_FFFC -> next insAddr=0x0. branchTarget=0x42 -> insAddr=0x42 and captured idMisalign=1.
- Async reset mid-run: assert rst between edges at PC=0x30 -> outputs reach reset values before the next edge, and the restart sequence repeats.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage constants and the per-edge action encoding.
// Imported by pc_fetch and if_id_reg.
package pc_fetch_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INS_W    = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic        INS_ENABLE   = 1'b1;
  localparam logic        INS_DISABLE  = 1'b0;

  typedef enum logic [1:0] {
    ACT_FETCH  = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } fetch_act_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble control.
// Only updates once the fetch enable is already high.
module if_id_reg
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INS_W  = DEF_INS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        act,
  input  logic [ADDR_W-1:0] pc,
  input  logic [INS_W-1:0]  inst,
  output logic [ADDR_W-1:0] idPc,
  output logic [INS_W-1:0]  idInst,
  output logic              idValid,
  output logic              idMisalign
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idPc       <= '0;
      idInst     <= '0;
      idValid    <= 1'b0;
      idMisalign <= 1'b0;
    end else if (en) begin
      unique case (act)
        ACT_FETCH: begin
          idPc       <= pc;
          idInst     <= inst;
          idValid    <= 1'b1;
          idMisalign <= (pc[1:0] != 2'b00);
        end
        ACT_HOLD: ;
        default: begin
          idPc       <= '0;
          idInst     <= '0;
          idValid    <= 1'b0;
          idMisalign <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch front end: PC, redirect priority, IF/ID register
// and the accepted-fetch counter.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INS_W    = DEF_INS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallIf,
  input  logic              stallId,
  input  logic              flush,
  input  logic [ADDR_W-1:0] newPc,
  input  logic              branchFlag,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic [INS_W-1:0]  inst,
  output logic              insEn,
  output logic [ADDR_W-1:0] insAddr,
  output logic [ADDR_W-1:0] idPc,
  output logic [INS_W-1:0]  idInst,
  output logic              idValid,
  output logic              idMisalign,
  output logic [31:0]       fetchCount
);

  logic [ADDR_W-1:0] pc;
  fetch_act_e        act;

  // stallId alone freezes both stages
  always_comb begin
    act = ACT_FETCH;
    if (flush)        act = ACT_FLUSH;
    else if (stallId) act = ACT_HOLD;
    else if (stallIf) act = ACT_BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insEn      <= INS_DISABLE;
      pc         <= RESET_PC;
      fetchCount <= ZERO_WORD;
    end else if (insEn == INS_DISABLE) begin
      insEn <= INS_ENABLE;
    end else begin
      unique case (act)
        ACT_FLUSH: pc <= newPc;
        ACT_FETCH: begin
          pc <= branchFlag ? branchTarget
                           : pc + ADDR_W'(PC_INC);
          fetchCount <= fetchCount + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign insAddr = pc;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INS_W  (INS_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (insEn),
    .act        (act),
    .pc         (pc),
    .inst       (inst),
    .idPc       (idPc),
    .idInst     (idInst),
    .idValid    (idValid),
    .idMisalign (idMisalign)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a reference model pushes the
// expected post-edge state, compared #1 after each edge.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallIf, stallId, flush, branchFlag;
  logic [31:0] newPc, branchTarget, inst;
  logic        insEn, idValid, idMisalign;
  logic [31:0] insAddr, idPc, idInst, fetchCount;

  always #5 clk = ~clk;

  // memory returns the word address as data
  assign inst = insAddr;

  pc_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stallIf      (stallIf),
    .stallId      (stallId),
    .flush        (flush),
    .newPc        (newPc),
    .branchFlag   (branchFlag),
    .branchTarget (branchTarget),
    .inst         (inst),
    .insEn        (insEn),
    .insAddr      (insAddr),
    .idPc         (idPc),
    .idInst       (idInst),
    .idValid      (idValid),
    .idMisalign   (idMisalign),
    .fetchCount   (fetchCount)
  );

  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic [31:0] idpc;
    logic [31:0] idinst;
    logic        v;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_reset();
    exp_t r;
    r = '0;
    return r;
  endfunction

  task automatic cmp_all(input exp_t e);
    chk("insEn", {31'd0, insEn}, {31'd0, e.en});
    chk("insAddr", insAddr, e.pc);
    chk("idPc", idPc, e.idpc);
    chk("idInst", idInst, e.idinst);
    chk("idValid", {31'd0, idValid}, {31'd0, e.v});
    chk("idMisalign", {31'd0, idMisalign}, {31'd0, e.mis});
    chk("fetchCount", fetchCount, e.cnt);
  endtask

  task automatic step(input logic fl, input logic [31:0] np,
                      input logic si, input logic sd,
                      input logic br, input logic [31:0] bt);
    exp_t e;
    flush = fl; newPc = np; stallIf = si; stallId = sd;
    branchFlag = br; branchTarget = bt;
    if (!m.en) begin
      m.en = 1'b1;
    end else if (fl) begin
      m.pc = np;
      m.idpc = 0; m.idinst = 0; m.v = 0; m.mis = 0;
    end else if (sd) begin
      m.cnt = m.cnt;
    end else if (si) begin
      m.idpc = 0; m.idinst = 0; m.v = 0; m.mis = 0;
    end else begin
      m.idpc = m.pc;
      m.idinst = m.pc;
      m.v = 1'b1;
      m.mis = (m.pc[1:0] != 2'b00);
      m.pc = br ? bt : m.pc + 32'd4;
      m.cnt = m.cnt + 1;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      cmp_all(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    {stallIf, stallId, flush, branchFlag} = '0;
    newPc = 0; branchTarget = 0;
    m = model_reset();
    #1;
    cmp_all(m);
    @(posedge clk); #1;
    cmp_all(m);
    rst = 1'b0;

    // reset release: enable edge, then 0x0, 0x4, 0x8
    idle();
    chk("en_after_edge1", {31'd0, insEn}, 32'd1);
    chk("pc_held_edge1", insAddr, 32'h0);
    idle(); idle(); idle();
    chk("cap_pc_8", idPc, 32'h8);
    chk("cnt_3", fetchCount, 32'd3);
    idle();
    chk("pc_at_10", insAddr, 32'h10);

    // branch with delay-slot capture
    step(0, 0, 0, 0, 1, 32'h40);
    chk("br_cap", idPc, 32'h10);
    chk("br_addr", insAddr, 32'h40);
    idle();
    chk("br_tgt_cap", idPc, 32'h40);

    // stallIf bubbles, then full stall and stallId-only stall
    step(1, 32'h20, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 32'h99);
    step(0, 0, 1, 0, 0, 0);
    chk("stall_addr", insAddr, 32'h20);
    chk("stall_bubble", {31'd0, idValid}, 32'd0);
    idle();
    step(0, 0, 1, 1, 1, 32'h500);
    chk("hold_pc", idPc, 32'h20);
    step(0, 0, 0, 1, 0, 0);
    chk("holdid_addr", insAddr, 32'h24);

    // flush beats stalls and branch
    step(1, 32'h180, 1, 1, 1, 32'h44);
    chk("flush_addr", insAddr, 32'h180);
    chk("flush_bubble", {31'd0, idValid}, 32'd0);
    idle();
    chk("flush_cap", idPc, 32'h180);

    // wrap and misaligned target
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    idle();
    chk("wrap", insAddr, 32'h0);
    step(0, 0, 0, 0, 1, 32'h42);
    chk("mis_addr", insAddr, 32'h42);
    idle();
    chk("mis_flag", {31'd0, idMisalign}, 32'd1);

    // random mix
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 9) == 0), $urandom & 32'hFFF,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0), $urandom & 32'hFFF);
    end

    // async reset between edges at PC=0x30
    step(1, 32'h30, 0, 0, 0, 0);
    chk("pre_rst_pc", insAddr, 32'h30);
    #2 rst = 1'b1;
    #1;
    m = model_reset();
    cmp_all(m);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    chk("restart_pc", insAddr, 32'h0);
    idle(); idle();
    chk("restart_cap", idPc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
